// File: rtl/header_lock_ctrl.sv
// Frame-sync controller: hunts for N_HDR consecutive HEADER words, forwards the
// payload until din_valid falls, and reports frame length/count and error pulses.
module header_lock_ctrl #(
   parameter int unsigned       DATA_W  = 16,
   parameter logic [DATA_W-1:0] HEADER  = 16'hBCBC,
   parameter int unsigned       N_HDR   = 6,
   parameter int unsigned       MAX_LEN = 256,
   parameter int unsigned       LEN_W   = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              din_valid,
   input  logic [DATA_W-1:0] din,
   output logic              locked,
   output logic              frame_start,
   output logic              payload_valid,
   output logic [DATA_W-1:0] payload_data,
   output logic              frame_end,
   output logic [LEN_W-1:0]  frame_len,
   output logic [15:0]       frame_cnt,
   output logic              hdr_err,
   output logic              ovf_err
);

   typedef enum logic [1:0] {S_HUNT, S_PAYLOAD, S_DISCARD} state_t;

   state_t              r_state;
   logic [3:0]          r_hcnt;
   logic [LEN_W-1:0]    r_len;
   logic                r_vd;
   logic                r_locked;
   logic                r_frame_start;
   logic                r_payload_valid;
   logic [DATA_W-1:0]   r_payload_data;
   logic                r_frame_end;
   logic [LEN_W-1:0]    r_frame_len;
   logic [15:0]         r_frame_cnt;
   logic                r_hdr_err;
   logic                r_ovf_err;

   logic                w_fall;
   logic                w_is_hdr;

   assign w_fall   = r_vd & ~din_valid;
   assign w_is_hdr = (din == HEADER);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state         <= S_HUNT;
         r_hcnt          <= '0;
         r_len           <= '0;
         r_vd            <= 1'b0;
         r_locked        <= 1'b0;
         r_frame_start   <= 1'b0;
         r_payload_valid <= 1'b0;
         r_payload_data  <= '0;
         r_frame_end     <= 1'b0;
         r_frame_len     <= '0;
         r_frame_cnt     <= '0;
         r_hdr_err       <= 1'b0;
         r_ovf_err       <= 1'b0;
      end else begin
         r_vd            <= din_valid;
         r_frame_start   <= 1'b0;
         r_payload_valid <= 1'b0;
         r_frame_end     <= 1'b0;
         r_hdr_err       <= 1'b0;
         r_ovf_err       <= 1'b0;
         case (r_state)
            S_HUNT: begin
               if (din_valid && w_is_hdr) begin
                  if (r_hcnt == 4'(N_HDR - 1)) begin
                     r_state       <= S_PAYLOAD;
                     r_hcnt        <= '0;
                     r_len         <= '0;
                     r_locked      <= 1'b1;
                     r_frame_start <= 1'b1;
                  end else begin
                     r_hcnt <= r_hcnt + 4'd1;
                  end
               end else begin
                  // Only a valid non-header word breaks a run; idle just restarts it.
                  if (din_valid && (r_hcnt != '0))
                     r_hdr_err <= 1'b1;
                  r_hcnt <= '0;
               end
            end
            S_PAYLOAD: begin
               if (w_fall) begin
                  r_state     <= S_HUNT;
                  r_locked    <= 1'b0;
                  r_frame_end <= 1'b1;
                  r_frame_len <= r_len;
                  r_frame_cnt <= r_frame_cnt + 16'd1;
               end else if (din_valid) begin
                  if (r_len == LEN_W'(MAX_LEN)) begin
                     r_state   <= S_DISCARD;
                     r_locked  <= 1'b0;
                     r_ovf_err <= 1'b1;
                  end else begin
                     r_payload_valid <= 1'b1;
                     r_payload_data  <= din;
                     r_len           <= r_len + 1'b1;
                  end
               end
            end
            S_DISCARD: begin
               if (!din_valid) begin
                  r_state <= S_HUNT;
                  r_hcnt  <= '0;
               end
            end
            default: r_state <= S_HUNT;
         endcase
      end
   end

   assign locked        = r_locked;
   assign frame_start   = r_frame_start;
   assign payload_valid = r_payload_valid;
   assign payload_data  = r_payload_data;
   assign frame_end     = r_frame_end;
   assign frame_len     = r_frame_len;
   assign frame_cnt     = r_frame_cnt;
   assign hdr_err       = r_hdr_err;
   assign ovf_err       = r_ovf_err;

endmodule

// File: tb/tb_header_lock_ctrl.sv
// Self-checking bench for header_lock_ctrl: vector table, directed frame
// sequences and random traffic against a behavioural frame model.
module tb_header_lock_ctrl;

   localparam int unsigned DW   = 16;
   localparam logic [15:0] HDR  = 16'hBCBC;
   localparam int unsigned NH   = 6;
   localparam int unsigned MAXL = 256;
   localparam int unsigned LW   = 9;

   logic          clk = 1'b0;
   logic          rst;
   logic          din_valid;
   logic [DW-1:0] din;
   logic          locked, frame_start, payload_valid, frame_end, hdr_err, ovf_err;
   logic [DW-1:0] payload_data;
   logic [LW-1:0] frame_len;
   logic [15:0]   frame_cnt;

   header_lock_ctrl #(
      .DATA_W (DW),
      .HEADER (HDR),
      .N_HDR  (NH),
      .MAX_LEN(MAXL),
      .LEN_W  (LW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .din_valid    (din_valid),
      .din          (din),
      .locked       (locked),
      .frame_start  (frame_start),
      .payload_valid(payload_valid),
      .payload_data (payload_data),
      .frame_end    (frame_end),
      .frame_len    (frame_len),
      .frame_cnt    (frame_cnt),
      .hdr_err      (hdr_err),
      .ovf_err      (ovf_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Behavioural frame model: integer counters and flags, expectations for the cycle after each edge.
   bit          m_prev_v, m_in_frame, m_drop;
   int          m_run, m_len, m_cnt;
   logic        e_locked, e_fs, e_pv, e_fe, e_he, e_oe;
   logic [15:0] e_pd;
   logic [LW-1:0] e_len;

   // Pulse bookkeeping for the directed sequences.
   int n_hdr_err, n_ovf, n_fe, n_pv;
   int fe_lens[$];

   typedef struct {
      logic          v;
      logic [15:0]   d;
      logic          lk, fs, pv;
      logic [15:0]   pd;
      logic          fe;
      logic [LW-1:0] len;
      logic [15:0]   cnt;
      logic          he, oe;
   } vec_t;
   vec_t tbl[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_prev_v = 0; m_in_frame = 0; m_drop = 0;
      m_run = 0; m_len = 0; m_cnt = 0;
      e_locked = 0; e_fs = 0; e_pv = 0; e_fe = 0; e_he = 0; e_oe = 0;
      e_pd = '0; e_len = '0;
   endtask

   task automatic model_step(input logic v, input logic [15:0] d);
      e_fs = 0; e_pv = 0; e_fe = 0; e_he = 0; e_oe = 0;
      if (m_drop) begin
         if (!v) begin m_drop = 0; m_run = 0; end
      end else if (m_in_frame) begin
         if (m_prev_v && !v) begin
            e_fe = 1; e_len = LW'(m_len);
            m_cnt = (m_cnt + 1) % 65536;
            m_in_frame = 0;
         end else if (v) begin
            if (m_len == MAXL) begin
               e_oe = 1; m_in_frame = 0; m_drop = 1;
            end else begin
               e_pv = 1; e_pd = d; m_len++;
            end
         end
      end else begin
         if (v && d == HDR) begin
            m_run++;
            if (m_run == NH) begin
               e_fs = 1; m_in_frame = 1; m_len = 0; m_run = 0;
            end
         end else begin
            if (v && m_run > 0) e_he = 1;
            m_run = 0;
         end
      end
      e_locked = m_in_frame;
      m_prev_v = v;
   endtask

   task automatic check_all();
      chk("locked",        {31'd0, locked},        {31'd0, e_locked});
      chk("frame_start",   {31'd0, frame_start},   {31'd0, e_fs});
      chk("payload_valid", {31'd0, payload_valid}, {31'd0, e_pv});
      chk("payload_data",  {16'd0, payload_data},  {16'd0, e_pd});
      chk("frame_end",     {31'd0, frame_end},     {31'd0, e_fe});
      chk("frame_len",     32'(frame_len),         32'(e_len));
      chk("frame_cnt",     {16'd0, frame_cnt},     32'(m_cnt));
      chk("hdr_err",       {31'd0, hdr_err},       {31'd0, e_he});
      chk("ovf_err",       {31'd0, ovf_err},       {31'd0, e_oe});
   endtask

   task automatic step(input logic v, input logic [15:0] d);
      din_valid = v;
      din       = d;
      model_step(v, d);
      @(posedge clk);
      @(negedge clk);
      check_all();
      if (hdr_err) n_hdr_err++;
      if (ovf_err) n_ovf++;
      if (payload_valid) n_pv++;
      if (frame_end) begin n_fe++; fe_lens.push_back(int'(frame_len)); end
   endtask

   task automatic hdr_run(input int n);
      for (int i = 0; i < n; i++) step(1'b1, HDR);
   endtask

   task automatic do_reset();
      din_valid = 1'b0;
      din       = '0;
      rst       = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      n_hdr_err = 0; n_ovf = 0; n_fe = 0; n_pv = 0;
      fe_lens.delete();
   endtask

   initial begin
      // Lock and pass-through: outputs expected after each input edge.
      tbl[0]  = '{1'b1, HDR,     0, 0, 0, 16'h0000, 0, 9'd0, 16'd0, 0, 0};
      tbl[1]  = '{1'b1, HDR,     0, 0, 0, 16'h0000, 0, 9'd0, 16'd0, 0, 0};
      tbl[2]  = '{1'b1, HDR,     0, 0, 0, 16'h0000, 0, 9'd0, 16'd0, 0, 0};
      tbl[3]  = '{1'b1, HDR,     0, 0, 0, 16'h0000, 0, 9'd0, 16'd0, 0, 0};
      tbl[4]  = '{1'b1, HDR,     0, 0, 0, 16'h0000, 0, 9'd0, 16'd0, 0, 0};
      tbl[5]  = '{1'b1, HDR,     1, 1, 0, 16'h0000, 0, 9'd0, 16'd0, 0, 0};
      tbl[6]  = '{1'b1, 16'h0001, 1, 0, 1, 16'h0001, 0, 9'd0, 16'd0, 0, 0};
      tbl[7]  = '{1'b1, 16'h0002, 1, 0, 1, 16'h0002, 0, 9'd0, 16'd0, 0, 0};
      tbl[8]  = '{1'b1, 16'h0003, 1, 0, 1, 16'h0003, 0, 9'd0, 16'd0, 0, 0};
      tbl[9]  = '{1'b1, 16'h0004, 1, 0, 1, 16'h0004, 0, 9'd0, 16'd0, 0, 0};
      tbl[10] = '{1'b0, 16'h0000, 0, 0, 0, 16'h0004, 1, 9'd4, 16'd1, 0, 0};
      tbl[11] = '{1'b0, 16'h0000, 0, 0, 0, 16'h0004, 0, 9'd4, 16'd1, 0, 0};

      rst = 1'b1; din_valid = 1'b0; din = '0;
      model_reset();
      #2;
      check_all();
      do_reset();
      check_all();

      for (int i = 0; i < 12; i++) begin
         din_valid = tbl[i].v;
         din       = tbl[i].d;
         model_step(tbl[i].v, tbl[i].d);
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("tbl%0d.locked", i),  {31'd0, locked},        {31'd0, tbl[i].lk});
         chk($sformatf("tbl%0d.fstart", i),  {31'd0, frame_start},   {31'd0, tbl[i].fs});
         chk($sformatf("tbl%0d.pvalid", i),  {31'd0, payload_valid}, {31'd0, tbl[i].pv});
         chk($sformatf("tbl%0d.pdata", i),   {16'd0, payload_data},  {16'd0, tbl[i].pd});
         chk($sformatf("tbl%0d.fend", i),    {31'd0, frame_end},     {31'd0, tbl[i].fe});
         chk($sformatf("tbl%0d.flen", i),    32'(frame_len),         32'(tbl[i].len));
         chk($sformatf("tbl%0d.fcnt", i),    {16'd0, frame_cnt},     {16'd0, tbl[i].cnt});
         chk($sformatf("tbl%0d.hdrerr", i),  {31'd0, hdr_err},       {31'd0, tbl[i].he});
         chk($sformatf("tbl%0d.ovferr", i),  {31'd0, ovf_err},       {31'd0, tbl[i].oe});
      end

      // Broken header run.
      do_reset();
      hdr_run(3);
      step(1'b1, 16'h1234);
      hdr_run(5);
      chk("broken.no_early_lock", {31'd0, locked}, 32'd0);
      hdr_run(1);
      chk("broken.lock", {31'd0, locked}, 32'd1);
      step(1'b1, 16'hAAAA);
      step(1'b1, 16'h5555);
      step(1'b0, '0);
      step(1'b0, '0);
      chk("broken.hdr_err_count", 32'(n_hdr_err), 32'd1);
      chk("broken.frame_len", 32'(frame_len), 32'd2);

      // Idle gap inside a header run restarts the count without error.
      do_reset();
      begin
         int first_lock = 0;
         for (int i = 1; i <= 12; i++) begin
            if (i == 6) step(1'b0, HDR);
            else        step(1'b1, HDR);
            if (locked && first_lock == 0) first_lock = i;
         end
         chk("gap.lock_step", 32'(first_lock), 32'd12);
      end
      step(1'b0, '0);
      chk("gap.hdr_err_count", 32'(n_hdr_err), 32'd0);

      // Zero-length frame followed directly by a one-word frame.
      do_reset();
      hdr_run(6);
      step(1'b0, '0);
      hdr_run(6);
      step(1'b1, 16'h55AA);
      step(1'b0, '0);
      step(1'b0, '0);
      chk("b2b.fe_count", 32'(n_fe), 32'd2);
      if (fe_lens.size() == 2) begin
         chk("b2b.len0", 32'(fe_lens[0]), 32'd0);
         chk("b2b.len1", 32'(fe_lens[1]), 32'd1);
      end else begin
         chk("b2b.len_records", 32'(fe_lens.size()), 32'd2);
      end
      chk("b2b.frame_cnt", {16'd0, frame_cnt}, 32'd2);

      // Payload overflow and recovery.
      do_reset();
      hdr_run(6);
      for (int i = 1; i <= 260; i++) step(1'b1, 16'(i));
      step(1'b0, '0);
      step(1'b0, '0);
      chk("ovf.pv_count", 32'(n_pv), 32'd256);
      chk("ovf.ovf_count", 32'(n_ovf), 32'd1);
      chk("ovf.fe_count", 32'(n_fe), 32'd0);
      chk("ovf.frame_cnt", {16'd0, frame_cnt}, 32'd0);
      hdr_run(6);
      chk("ovf.relock", {31'd0, locked}, 32'd1);
      step(1'b0, '0);
      chk("ovf.close_cnt", {16'd0, frame_cnt}, 32'd1);

      // Asynchronous reset in the middle of a payload.
      do_reset();
      hdr_run(6);
      step(1'b1, 16'h1111);
      step(1'b1, 16'h2222);
      din_valid = 1'b1; din = 16'h3333;
      #2 rst = 1'b1;
      #1;
      chk("arst.locked", {31'd0, locked}, 32'd0);
      chk("arst.pvalid", {31'd0, payload_valid}, 32'd0);
      chk("arst.pdata",  {16'd0, payload_data}, 32'd0);
      chk("arst.fend",   {31'd0, frame_end}, 32'd0);
      chk("arst.flen",   32'(frame_len), 32'd0);
      chk("arst.fcnt",   {16'd0, frame_cnt}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      n_fe = 0;
      hdr_run(6);
      step(1'b1, 16'h0A0A);
      step(1'b1, 16'h0B0B);
      step(1'b0, '0);
      chk("arst.fe_count", 32'(n_fe), 32'd1);
      chk("arst.relen", 32'(frame_len), 32'd2);

      // Randomised traffic.
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         logic        v;
         logic [15:0] d;
         v = ($urandom_range(0, 15) != 0);
         d = ($urandom_range(0, 3) != 0) ? HDR : 16'($urandom);
         step(v, d);
      end
      step(1'b0, '0);

      // frame_cnt wrap after force-loading the counter.
      do_reset();
      force dut.r_frame_cnt = 16'hFFFF;
      #1;
      release dut.r_frame_cnt;
      m_cnt = 65535;
      chk("wrap.loaded", {16'd0, frame_cnt}, 32'h0000_FFFF);
      hdr_run(6);
      step(1'b1, 16'h7777);
      step(1'b0, '0);
      chk("wrap.zero", {16'd0, frame_cnt}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/header_lock_ctrl.md
# header_lock_ctrl

Frame-sync controller for the SFP receive word stream. It hunts for 6 consecutive header words and then passes the payload words through. It ends each frame on the falling edge of the input valid, and reports frame length, frame count and error events. It sits between the SFP deserialiser word output and the downstream frame buffer.

## Interface
Parameters:
- DATA_W, 16, word width
- HEADER, 16'hBCBC, header word value
- N_HDR, 6, consecutive header words required for lock (2..15)
- MAX_LEN, 256, maximum payload words per frame
- LEN_W, 9, width of length counter; must satisfy MAX_LEN ≤ 2^LEN_W − 1

Ports:
- clk  in  1  system clock; all logic on its rising edge
- rst  in  1  asynchronous, active-high reset
- din_valid  in  1  input word valid
- din  in  DATA_W  input word
- locked  out  1  high while in PAYLOAD state
- frame_start  out  1  one-cycle pulse on header lock
- payload_valid  out  1  payload word strobe
- payload_data  out  DATA_W  payload word
- frame_end  out  1  one-cycle pulse at frame close
- frame_len  out  LEN_W  payload word count of the last closed frame; held until the next close
- frame_cnt  out  16  closed frames since reset; wraps 16'hFFFF→0
- hdr_err  out  1  one-cycle pulse on a broken header run
- ovf_err  out  1  one-cycle pulse on payload overflow

## Operation
- Internal din_valid_d register: din_valid delayed one cycle. Falling edge is defined as din_valid_d=1 and din_valid=0.
- States:
  - HUNT: hcnt counts consecutive valid words equal to HEADER.
    - Valid non-header word: hcnt←0. If hcnt was ≥1, pulse hdr_err.
    - din_valid=0: hcnt←0, with no error.
    - When the N_HDR-th consecutive header word is accepted: go to PAYLOAD, len←0, pulse frame_start.
  - PAYLOAD: each valid word is forwarded on payload_data/payload_valid and len increments. Header-valued words are payload here.
    - Falling edge: pulse frame_end, frame_len←len, frame_cnt+1, go to HUNT. A zero-length frame is legal and reports frame_len=0.
    - Valid word arriving when len==MAX_LEN: the word is dropped, ovf_err pulses, frame_cnt and frame_len are unchanged, go to DISCARD.
  - DISCARD: ignore all words. Go to HUNT in the cycle after din_valid is seen low. No frame_end is produced.
- Simultaneous events: a falling edge in PAYLOAD takes priority; no new word can coincide with it, since din_valid=0.
- Reset mid-frame: the partial frame is lost. No frame_end is produced and no error pulses.

## Timing
- All outputs are registered.
- Reset values: locked=0, frame_start=0, payload_valid=0, payload_data=0, frame_end=0, frame_len=0, frame_cnt=0, hdr_err=0, ovf_err=0. State=HUNT, hcnt=0, len=0, din_valid_d=0.
- frame_start and locked go high in the cycle after the N_HDR-th header word is sampled.
- The first payload word may arrive in the very next cycle after the lock word.
- Payload latency is 1 cycle: a word sampled at edge k appears on payload_data at k+1, with payload_valid=1 for exactly that cycle.
- frame_end rises the cycle after the first din_valid=0 sample. frame_len and frame_cnt update in that same cycle. locked falls in that same cycle.
- hdr_err and ovf_err are 1 cycle after the offending word.
- Back-to-back frames are supported: a new header run may begin on the first cycle din_valid returns high after frame_end.

## Test plan
- Lock and pass-through: 6×BCBC, then words 0001..0004, then din_valid=0.
  - frame_start 1 cycle after the 6th header.
  - payload 0001..0004 each 1 cycle late.
  - frame_end with frame_len=4, frame_cnt=1.
- Broken header: 3×BCBC, then 1234, then 6×BCBC, then 2 words, then idle.
  - hdr_err pulses once after 1234.
  - Lock only after the second run; frame_len=2.
- Gap in header run: 5×BCBC, 1 idle cycle, 6×BCBC.
  - No hdr_err.
  - Lock after the 12th header-valued word total, not earlier.
- Zero-length and back-to-back: 6×BCBC, idle, then 6×BCBC + 1 word, idle.
  - Two frame_end pulses with frame_len=0 then 1; frame_cnt=2.
- Overflow: lock, then 257 valid words, then 3 more, then idle.
  - 256 payload strobes, then ovf_err 1 cycle after word 257.
  - No frame_end; frame_cnt unchanged.
  - Next 6×BCBC locks normally.
- Async reset mid-frame: assert rst for 1 cycle halfway through a payload.
  - All outputs go to reset values immediately.
  - No frame_end; a fresh header run locks afterwards.
  - frame_cnt wrap is checked by force-loading 16'hFFFF and closing one frame → 0.
